// File: rtl/multi_queue_fifo_pkg.sv
// Shared defaults and a width helper for the multi-queue FIFO and its
// per-queue controller.
package multi_queue_fifo_pkg;

    localparam int DEFAULT_WIDTH      = 64;
    localparam int DEFAULT_NUM_QUEUES = 4;
    localparam int DEFAULT_DEPTH      = 8;

    // An occupancy counter must reach DEPTH itself, so it needs one bit more
    // than a pointer into the queue.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_queue_ctrl.sv
// Book-keeping for one queue: head/tail pointers, occupancy and the
// accept/flush decisions. Pointers wrap naturally at DEPTH (power of two).
module fifo_queue_ctrl
    import multi_queue_fifo_pkg::*;
#(
    parameter  int DEPTH     = DEFAULT_DEPTH,
    localparam int PTR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH = count_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 enq,
    input  logic                 deq,
    output logic [PTR_WIDTH-1:0] head,
    output logic [PTR_WIDTH-1:0] tail,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 enq_ok,
    output logic                 deq_ok
);

    // A flush swallows any colliding operation; otherwise full blocks
    // enqueue and empty blocks dequeue, judged on start-of-cycle count.
    assign enq_ok = enq && !flush && (count != CNT_WIDTH'(DEPTH));
    assign deq_ok = deq && !flush && (count != '0);

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, matching real flip-flops.
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_ok) tail <= tail + PTR_WIDTH'(1);
            if (deq_ok) head <= head + PTR_WIDTH'(1);
            count <= count + CNT_WIDTH'(enq_ok) - CNT_WIDTH'(deq_ok);
        end
    end

endmodule

// File: rtl/multi_queue_fifo.sv
// NUM_QUEUES independent FIFOs sharing one storage array, each queue owning
// DEPTH consecutive entries at address {queue, pointer}. Illegal operations
// are dropped and latched into sticky error flags.
module multi_queue_fifo
    import multi_queue_fifo_pkg::*;
#(
    parameter  int WIDTH                  = DEFAULT_WIDTH,
    parameter  int NUM_QUEUES             = DEFAULT_NUM_QUEUES,
    parameter  int DEPTH                  = DEFAULT_DEPTH,
    parameter  int ALMOST_FULL_THRESHOLD  = DEPTH,
    parameter  int ALMOST_EMPTY_THRESHOLD = 1,
    localparam int QID_WIDTH              = $clog2(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_QUEUES-1:0] flush_en,
    input  logic                  enqueue_en,
    input  logic [QID_WIDTH-1:0]  enqueue_queue,
    input  logic [WIDTH-1:0]      enqueue_value,
    input  logic                  dequeue_en,
    input  logic [QID_WIDTH-1:0]  dequeue_queue,
    output logic [WIDTH-1:0]      dequeue_value,
    output logic [NUM_QUEUES-1:0] full,
    output logic [NUM_QUEUES-1:0] almost_full,
    output logic [NUM_QUEUES-1:0] empty,
    output logic [NUM_QUEUES-1:0] almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int PTR_WIDTH  = $clog2(DEPTH);
    localparam int CNT_WIDTH  = count_width(DEPTH);
    localparam int ADDR_WIDTH = QID_WIDTH + PTR_WIDTH;

    logic [PTR_WIDTH-1:0]  head  [NUM_QUEUES];
    logic [PTR_WIDTH-1:0]  tail  [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]  count [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] enq_vec, deq_vec, enq_ok, deq_ok;

    // One controller per queue, plus the per-queue status flags.
    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        assign enq_vec[g] = enqueue_en && (enqueue_queue == QID_WIDTH'(g));
        assign deq_vec[g] = dequeue_en && (dequeue_queue == QID_WIDTH'(g));

        fifo_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush_en[g]),
            .enq    (enq_vec[g]),
            .deq    (deq_vec[g]),
            .head   (head[g]),
            .tail   (tail[g]),
            .count  (count[g]),
            .enq_ok (enq_ok[g]),
            .deq_ok (deq_ok[g])
        );

        assign full[g]         = (count[g] == CNT_WIDTH'(DEPTH));
        assign empty[g]        = (count[g] == '0);
        assign almost_full[g]  = (count[g] >= CNT_WIDTH'(ALMOST_FULL_THRESHOLD));
        assign almost_empty[g] = (count[g] <= CNT_WIDTH'(ALMOST_EMPTY_THRESHOLD));
    end

    // A rejection is a request that was neither accepted nor flushed away.
    logic enq_accept, enq_reject, deq_reject;
    assign enq_accept = |enq_ok;
    assign enq_reject = |(enq_vec & ~flush_en & ~enq_ok);
    assign deq_reject = |(deq_vec & ~flush_en & ~deq_ok);

    // Select the write tail and read head of the addressed queues.
    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                 rd_valid;
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        wr_ptr   = '0;
        rd_ptr   = '0;
        rd_valid = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (enq_vec[q]) wr_ptr = tail[q];
            if (dequeue_queue == QID_WIDTH'(q)) begin
                rd_ptr   = head[q];
                rd_valid = (count[q] != '0);
            end
        end
    end

    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    assign wr_addr = {enqueue_queue, wr_ptr};
    assign rd_addr = {dequeue_queue, rd_ptr};

`ifdef VENDOR_ALTERA
    (* ramstyle = "MLAB, no_rw_check" *)
    logic [WIDTH-1:0] mem [NUM_QUEUES*DEPTH];
`elsif MEMORY_COMPILER
    (* mem_compiler = "1w1r_async_read" *)
    logic [WIDTH-1:0] mem [NUM_QUEUES*DEPTH];
`else
    logic [WIDTH-1:0] mem [NUM_QUEUES*DEPTH];
`endif

    // Storage write for accepted enqueues only.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; stale entries are unreachable once
        // the counts are cleared, and leaving it unreset allows RAM mapping.
        if (enq_accept && !reset) mem[wr_addr] <= enqueue_value;
    end

    // Show-ahead read of the selected head; zero when that queue is empty.
    assign dequeue_value = rd_valid ? mem[rd_addr] : '0;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (enq_reject) overflow_err  <= 1'b1;
            if (deq_reject) underflow_err <= 1'b1;
        end
    end

endmodule

// File: doc/multi_queue_fifo.md
# multi_queue_fifo

Synchronous FIFO holding NUM_QUEUES independent queues in one shared storage array, each queue statically allotted DEPTH entries. One enqueue port and one dequeue port each carry a queue index, so a single block replaces a bank of separate FIFOs; examples are per-thread or per-requester buffering in the L2 and I/O paths. Adds three things a plain FIFO lacks: per-queue synchronous flush, per-queue status vectors, and sticky overflow/underflow error flags. Illegal operations are dropped rather than corrupting state.

## Interface
- WIDTH, 64, data bits per entry
- NUM_QUEUES, 4, number of queues; must be at least 2
- DEPTH, 8, entries per queue; must be a power of two and at least 2
- ALMOST_FULL_THRESHOLD, DEPTH, almost_full asserts when count >= this value
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserts when count <= this value
- Derived: QID_WIDTH = $clog2(NUM_QUEUES); PTR_WIDTH = $clog2(DEPTH); count width PTR_WIDTH+1
- clk  input  1  clock; everything is sampled on the rising edge
- reset  input  1  reset; synchronous, active-high
- flush_en  input  NUM_QUEUES  per-queue synchronous flush mask
- enqueue_en  input  1  enqueue request
- enqueue_queue  input  QID_WIDTH  target queue for the enqueue
- enqueue_value  input  WIDTH  data to enqueue
- dequeue_en  input  1  dequeue request
- dequeue_queue  input  QID_WIDTH  source queue for the dequeue and for dequeue_value
- dequeue_value  output  WIDTH  head of dequeue_queue (show-ahead); 0 when that queue is empty
- full  output  NUM_QUEUES  count == DEPTH, per queue
- almost_full  output  NUM_QUEUES  per-queue threshold flag
- empty  output  NUM_QUEUES  count == 0, per queue
- almost_empty  output  NUM_QUEUES  per-queue threshold flag
- overflow_err  output  1  sticky; set by an enqueue to a full queue
- underflow_err  output  1  sticky; set by a dequeue from an empty queue

## Operation
- Per queue q, registered state: head[q], tail[q] (each PTR_WIDTH bits) and count[q].
- Storage address for queue q, pointer p is {q, p}. Pointers wrap naturally at DEPTH.
- Accepted enqueue: data[{enqueue_queue, tail}] <= enqueue_value; tail and count advance.
- Accepted dequeue: head advances, count decrements.
- Enqueue and dequeue on the same queue in the same cycle:
  - both accepted; count unchanged
  - valid only if the queue is neither full nor empty at the start of the cycle
- Enqueue to a full queue is rejected, even with a same-queue dequeue in that cycle:
  - the write is dropped; overflow_err <= 1
  - a concurrent legal dequeue still proceeds
- Dequeue from an empty queue is rejected:
  - no state change; underflow_err <= 1
  - a concurrent legal enqueue still proceeds
- flush_en[q] has priority over any enqueue or dequeue targeting q in that cycle:
  - head, tail and count of q go to 0
  - the colliding operation is dropped silently and raises no error
  - other queues are unaffected and proceed normally
- Error flags clear only on reset.
- Status outputs are combinational from count[]; dequeue_value is a combinational read of the head entry.
- Storage contents are not reset.

## Timing
- Reset values: all counts 0, so empty = all ones, almost_empty = all ones, full = 0, almost_full = 0 (ALMOST_FULL_THRESHOLD >= 1), dequeue_value = 0, both error flags 0.
- Reset during operation discards all queued data on the next edge. Reset overrides flush, enqueue and dequeue.
- Enqueue into an empty queue:
  - empty[q] deasserts the cycle after the edge
  - dequeue_value shows the data that same cycle
  - there is no same-cycle write-through
- After a dequeue, the next entry appears on dequeue_value the cycle after the edge.
- Error flags assert the cycle after the offending edge.
- Throughput: one enqueue and one dequeue per cycle, to the same or different queues.

## Structure
- No new shared-package types; derived widths are localparams.
- Sub-module fifo_queue_ctrl holds one queue's head/tail/count and its accept/flush logic:
  - inputs: flush, enq, deq
  - outputs: head, tail, count, enq_ok, deq_ok
  - instantiated NUM_QUEUES times in a generate loop
- Top level holds the storage array, the index decode, the output muxes and the error flags.
- Keep the same VENDOR_ALTERA / MEMORY_COMPILER storage hooks as the other FIFOs. The storage is a 1-write/1-read array of NUM_QUEUES*DEPTH x WIDTH.

## Test plan
- Reset, then check: empty = 4'b1111, full = 0, dequeue_value = 0, error flags 0.
- Fill queue 2 with 8 values (0x10..0x17) while enqueuing 0xAA to queue 0. Expect full = 4'b0100, empty = 4'b1010, and queue 0's head = 0xAA. Drain queue 2 and check values in order.
- Wrap-around: run 20 interleaved enqueue/dequeue cycles on queue 1, holding occupancy between 1 and 7. Data order must be preserved and count must stay consistent across pointer wrap.
- Same-queue enqueue+dequeue at count 3 -> count stays 3. Enqueue to full queue 3 plus a dequeue of queue 3 -> overflow_err = 1 and count = 7. Dequeue from empty queue 0 -> underflow_err = 1 with no state change.
- flush_en = 4'b0010 while enqueuing to queue 1 and dequeuing from queue 3 -> queue 1 is empty with no error, and the queue 3 dequeue completes.
- Assert reset mid-stream with all queues partially full -> every status bit returns to its reset value on the next cycle.
